uart_tx_queue: RTL

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_tx_queue.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the queued UART transmitter.
//   DELAY_FRAMES_DEFAULT : clock cycles per bit (27 MHz / 115200 baud)
//   DATA_BITS            : payload bits per frame
//   FRAME_BITS           : start + data + stop bits per frame
//   txState_t            : serializer FSM state encoding
package uart_pkg;

    localparam int unsigned DELAY_FRAMES_DEFAULT = 234;
    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned FRAME_BITS           = 10;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } txState_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular FIFO with occupancy count.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   push       : write pushData at the tail (ignored when full)
//   pop        : advance the head (ignored when empty)
//   popData    : current head entry (valid when not empty)
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign popData = mem[rdPtr];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue feeding an 8N1 UART serializer.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   in_data    : byte to transmit
//   in_valid   : producer offers in_data this cycle
//   in_ready   : queue can accept a byte (not full)
//   uart_tx    : registered serial line, idle high
//   busy       : a frame is being shifted out
//   count      : bytes currently queued
//   overflow   : sticky, set when a byte was offered while full
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned DELAY_FRAMES = DELAY_FRAMES_DEFAULT,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     uart_tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned CNT_W = $clog2(DELAY_FRAMES);

    generate
        if (DELAY_FRAMES < 2) begin : gBadDelay
            $error("DELAY_FRAMES must be at least 2");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
            $error("DEPTH must be a power of two, at least 2");
        end
    endgenerate

    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [7:0]           fifoData;
    logic                 pushReq;
    logic                 popReq;
    logic                 lastCycle;

    txState_t             state;
    logic [DATA_BITS-1:0] shiftReg;
    logic [2:0]           bitIdx;
    logic [CNT_W-1:0]     cycleCnt;
    logic                 txReg;
    logic                 busyReg;
    logic                 overflowReg;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) uFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (pushReq),
        .pushData (in_data),
        .pop      (popReq),
        .popData  (fifoData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (count)
    );

    // Ready depends only on full, so a pop in the same cycle never frees a slot early.
    assign in_ready = !fifoFull;
    assign pushReq  = in_valid && in_ready;

    assign lastCycle = (({1'b0, cycleCnt} + (CNT_W+1)'(1)) == (CNT_W+1)'(DELAY_FRAMES));

    // Pop from IDLE, or on the final stop-bit cycle to chain frames without a gap.
    assign popReq = !fifoEmpty &&
                    ((state == TX_IDLE) || ((state == TX_STOP) && lastCycle));

    assign uart_tx  = txReg;
    assign busy     = busyReg;
    assign overflow = overflowReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflowReg <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflowReg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TX_IDLE;
            shiftReg <= '0;
            bitIdx   <= '0;
            cycleCnt <= '0;
            txReg    <= 1'b1;
            busyReg  <= 1'b0;
        end else begin
            case (state)
                TX_IDLE: begin
                    txReg <= 1'b1;
                    if (popReq) begin
                        shiftReg <= fifoData;
                        bitIdx   <= '0;
                        cycleCnt <= '0;
                        txReg    <= 1'b0;
                        busyReg  <= 1'b1;
                        state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (lastCycle) begin
                        cycleCnt <= '0;
                        txReg    <= shiftReg[0];
                        state    <= TX_DATA;
                    end else begin
                        cycleCnt <= cycleCnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (lastCycle) begin
                        cycleCnt <= '0;
                        if (bitIdx == 3'(DATA_BITS - 1)) begin
                            txReg <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                            txReg  <= shiftReg[bitIdx + 3'd1];
                        end
                    end else begin
                        cycleCnt <= cycleCnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (lastCycle) begin
                        cycleCnt <= '0;
                        if (popReq) begin
                            shiftReg <= fifoData;
                            bitIdx   <= '0;
                            txReg    <= 1'b0;
                            state    <= TX_START;
                        end else begin
                            busyReg <= 1'b0;
                            state   <= TX_IDLE;
                        end
                    end else begin
                        cycleCnt <= cycleCnt + CNT_W'(1);
                    end
                end
                default: begin
                    txReg   <= 1'b1;
                    busyReg <= 1'b0;
                    state   <= TX_IDLE;
                end
            endcase
        end
    end

endmodule
